// File: rtl/dmem_rmw_ctrl_if.sv
// Request, response and RAM-port signal bundle for dmem_rmw_ctrl.
// The controller uses the slave modport; the core/RAM side uses master.
interface dmem_rmw_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BE_W   = DATA_W / 8;

  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_wen;
  logic [ADDR_W-1:0] i_req_addr;
  logic [BE_W-1:0]   i_req_be;
  logic [DATA_W-1:0] i_req_data;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [DATA_W-1:0] o_rsp_data;
  logic              o_ram_en;
  logic              o_ram_wen;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_data;
  logic [DATA_W-1:0] i_ram_data;

  modport slave (
    input  i_req_valid, i_req_wen, i_req_addr, i_req_be, i_req_data,
    input  i_rsp_ready, i_ram_data,
    output o_req_ready, o_rsp_valid, o_rsp_data,
    output o_ram_en, o_ram_wen, o_ram_addr, o_ram_data
  );

  modport master (
    output i_req_valid, i_req_wen, i_req_addr, i_req_be, i_req_data,
    output i_rsp_ready, i_ram_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data,
    input  o_ram_en, o_ram_wen, o_ram_addr, o_ram_data
  );
endinterface

// File: rtl/dmem_rmw_ctrl.sv
// Load/store controller for a single-port read-first data RAM with one-cycle read latency.
// Define PQR5_DMEM_RMW_EN to turn sub-word stores into a read-modify-write sequence.
module dmem_rmw_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input logic           clk,
  input logic           aresetn,
  dmem_rmw_ctrl_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BE_W   = DATA_W / 8;

`ifdef PQR5_DMEM_RMW_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_RSP = 2'd1,
    RMW_WR = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_RSP = 2'd1
  } state_t;
`endif

  state_t            state_r;
  state_t            state_nxt;
  logic              ready_en_r;
  logic [DATA_W-1:0] rsp_data_r;

`ifdef PQR5_DMEM_RMW_EN
  logic [ADDR_W-1:0] rmw_addr_r;
  logic [BE_W-1:0]   rmw_be_r;
  logic [DATA_W-1:0] rmw_data_r;
  logic              rmw_capture;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [BE_W-1:0]   be,
    input logic [DATA_W-1:0] new_word,
    input logic [DATA_W-1:0] old_word
  );
    logic [DATA_W-1:0] m;
    m = '0;
    for (int k = 0; k < BE_W; k++) begin
      m[k*8 +: 8] = be[k] ? new_word[k*8 +: 8] : old_word[k*8 +: 8];
    end
    return m;
  endfunction
`endif

  // State register; ready_en_r keeps o_req_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r    <= IDLE;
      ready_en_r <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      ready_en_r <= 1'b1;
    end
  end

  // Last delivered load word, shown on o_rsp_data outside RD_RSP
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rsp_data_r <= {DATA_W{1'b0}};
    end else if (state_r == RD_RSP) begin
      rsp_data_r <= bus.i_ram_data;
    end else begin
      rsp_data_r <= rsp_data_r;
    end
  end

`ifdef PQR5_DMEM_RMW_EN
  // Merge registers hold the partial store across the RAM read cycle
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rmw_addr_r <= {ADDR_W{1'b0}};
      rmw_be_r   <= {BE_W{1'b0}};
      rmw_data_r <= {DATA_W{1'b0}};
    end else if (rmw_capture) begin
      rmw_addr_r <= bus.i_req_addr;
      rmw_be_r   <= bus.i_req_be;
      rmw_data_r <= bus.i_req_data;
    end else begin
      rmw_addr_r <= rmw_addr_r;
      rmw_be_r   <= rmw_be_r;
      rmw_data_r <= rmw_data_r;
    end
  end
`endif

  // Next-state and RAM/handshake outputs; the RAM port follows the request in the accept cycle
  always_comb begin
    state_nxt       = state_r;
    bus.o_req_ready = 1'b0;
    bus.o_rsp_valid = 1'b0;
    bus.o_rsp_data  = rsp_data_r;
    bus.o_ram_en    = 1'b0;
    bus.o_ram_wen   = 1'b0;
    bus.o_ram_addr  = {ADDR_W{1'b0}};
    bus.o_ram_data  = {DATA_W{1'b0}};
`ifdef PQR5_DMEM_RMW_EN
    rmw_capture     = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        bus.o_req_ready = ready_en_r;
        if (bus.i_req_valid && ready_en_r) begin
          if (!bus.i_req_wen) begin
            bus.o_ram_en   = 1'b1;
            bus.o_ram_addr = bus.i_req_addr;
            state_nxt      = RD_RSP;
`ifdef PQR5_DMEM_RMW_EN
          end else if (bus.i_req_be == {BE_W{1'b1}}) begin
            bus.o_ram_en   = 1'b1;
            bus.o_ram_wen  = 1'b1;
            bus.o_ram_addr = bus.i_req_addr;
            bus.o_ram_data = bus.i_req_data;
            state_nxt      = IDLE;
          end else if (bus.i_req_be != {BE_W{1'b0}}) begin
            bus.o_ram_en   = 1'b1;
            bus.o_ram_addr = bus.i_req_addr;
            rmw_capture    = 1'b1;
            state_nxt      = RMW_WR;
          end else begin
            // Empty store: consumed without touching the RAM
            state_nxt = IDLE;
          end
`else
          end else begin
            bus.o_ram_en   = 1'b1;
            bus.o_ram_wen  = 1'b1;
            bus.o_ram_addr = bus.i_req_addr;
            bus.o_ram_data = bus.i_req_data;
            state_nxt      = IDLE;
          end
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      RD_RSP: begin
        // RAM output is held because the port is disabled here
        bus.o_rsp_valid = 1'b1;
        bus.o_rsp_data  = bus.i_ram_data;
        if (bus.i_rsp_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RD_RSP;
        end
      end
`ifdef PQR5_DMEM_RMW_EN
      RMW_WR: begin
        bus.o_ram_en   = 1'b1;
        bus.o_ram_wen  = 1'b1;
        bus.o_ram_addr = rmw_addr_r;
        bus.o_ram_data = merge_bytes(rmw_be_r, rmw_data_r, bus.i_ram_data);
        state_nxt      = IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Scoreboard bench for dmem_rmw_ctrl: directed scenarios plus randomized traffic checked
// against a word-array reference model; honours PQR5_DMEM_RMW_EN like the design.
module tb_dmem_rmw_ctrl;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
  localparam int BE_W   = 4;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  dmem_rmw_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  dmem_rmw_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (.clk(clk), .aresetn(aresetn), .bus(bus));

  function automatic logic [DATA_W-1:0] pattern(input int i);
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Physical RAM: read-first, one-cycle latency, preloaded on the first edge (under reset)
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] ram_q;
  bit preloaded;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= pattern(i);
      preloaded <= 1'b1;
    end else if (bus.o_ram_en) begin
      ram_q <= ram[bus.o_ram_addr];
      if (bus.o_ram_wen) ram[bus.o_ram_addr] <= bus.o_ram_data;
    end
  end
  assign bus.i_ram_data = ram_q;

  // Reference model
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rand_rsp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_apply(input logic wen, input logic [ADDR_W-1:0] addr, input logic [BE_W-1:0] be,
                             input logic [DATA_W-1:0] data, input bit commit);
    if (!wen) begin
      exp_q.push_back(ref_mem[addr]);
    end else if (commit) begin
`ifdef PQR5_DMEM_RMW_EN
      for (int k = 0; k < BE_W; k++)
        if (be[k]) ref_mem[addr][k*8 +: 8] = data[k*8 +: 8];
`else
      ref_mem[addr] = data;
`endif
    end
  endtask

  // Present a request; returns at the negedge of the accept cycle with valid still high
  task automatic issue(input logic wen, input logic [ADDR_W-1:0] addr, input logic [BE_W-1:0] be,
                       input logic [DATA_W-1:0] data, input bit commit);
    bus.i_req_valid = 1'b1;
    bus.i_req_wen   = wen;
    bus.i_req_addr  = addr;
    bus.i_req_be    = be;
    bus.i_req_data  = data;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.o_req_ready) begin
        model_apply(wen, addr, be, data, commit);
        return;
      end
      @(posedge clk); #1;
    end
    check("req_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, {31'd0, bus.o_rsp_valid}, 32'd0);
    check({tag, "_req_ready"}, {31'd0, bus.o_req_ready}, 32'd0);
    check({tag, "_rsp_data"},  bus.o_rsp_data, 32'd0);
    check({tag, "_ram_en"},    {31'd0, bus.o_ram_en}, 32'd0);
    check({tag, "_ram_wen"},   {31'd0, bus.o_ram_wen}, 32'd0);
    check({tag, "_ram_addr"},  {22'd0, bus.o_ram_addr}, 32'd0);
    check({tag, "_ram_data"},  bus.o_ram_data, 32'd0);
  endtask

  // Random response backpressure
  always @(posedge clk) begin
    #1;
    if (rand_rsp) bus.i_rsp_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on each response handshake and checks hold-under-stall
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  always @(negedge clk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("rsp_hold_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
        check("rsp_hold_data", bus.o_rsp_data, prev_data);
      end
      if (bus.o_rsp_valid && bus.i_rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else check("rsp_data", bus.o_rsp_data, exp_q.pop_front());
      end
      prev_stall = bus.o_rsp_valid && !bus.i_rsp_ready;
      prev_data  = bus.o_rsp_data;
    end
  end

  logic [DATA_W-1:0] rnd;
  int wrcnt, t0, t1, sel;
  bit rmw_commit;

  initial begin
    bus.i_req_valid = 1'b0; bus.i_req_wen = 1'b0; bus.i_req_addr = '0;
    bus.i_req_be = '0; bus.i_req_data = '0; bus.i_rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pattern(i);

    // Reset values and release
    @(negedge clk);
    check_reset_outputs("reset");
    repeat (2) @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk); @(negedge clk);
    check("ready_after_release", {31'd0, bus.o_req_ready}, 32'd1);
    @(posedge clk); #1;

    // Load with response backpressure
    issue(1'b1, 10'h10, 4'hF, 32'hDEAD_BEEF, 1'b1); tick();
    bus.i_rsp_ready = 1'b0;
    issue(1'b0, 10'h10, 4'h0, 32'h0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
      check("bp_rsp_data", bus.o_rsp_data, 32'hDEAD_BEEF);
      check("bp_req_ready", {31'd0, bus.o_req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.i_rsp_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check("bp_idle_rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    check("bp_idle_req_ready", {31'd0, bus.o_req_ready}, 32'd1);
    @(posedge clk); #1;

    // Partial store merges into the existing word
    issue(1'b1, 10'd5, 4'hF, 32'h1122_3344, 1'b1); tick();
    issue(1'b1, 10'd5, 4'b0101, 32'hAABB_CCDD, 1'b1);
`ifdef PQR5_DMEM_RMW_EN
    check("ps_read_en", {30'd0, bus.o_ram_en, bus.o_ram_wen}, 32'd2);
    check("ps_read_addr", {22'd0, bus.o_ram_addr}, 32'd5);
    tick();
    @(negedge clk);
    check("ps_write_en", {30'd0, bus.o_ram_en, bus.o_ram_wen}, 32'd3);
    check("ps_write_addr", {22'd0, bus.o_ram_addr}, 32'd5);
    check("ps_write_data", bus.o_ram_data, 32'h11BB_33DD);
    check("ps_write_busy", {31'd0, bus.o_req_ready}, 32'd0);
`else
    check("ps_write_en", {30'd0, bus.o_ram_en, bus.o_ram_wen}, 32'd3);
    check("ps_write_data", bus.o_ram_data, 32'hAABB_CCDD);
    tick();
    @(negedge clk);
`endif
    @(posedge clk); #1;
    issue(1'b0, 10'd5, 4'h0, 32'h0, 1'b1); tick();

    // Back-to-back full stores
    wrcnt = 0;
    for (int i = 0; i < 8; i++) begin
      rnd = $urandom;
      issue(1'b1, ADDR_W'(i), 4'hF, rnd, 1'b1);
      if (i == 0) t0 = cyc;
      if (i == 7) t1 = cyc;
      if (bus.o_ram_en && bus.o_ram_wen && bus.o_ram_addr == ADDR_W'(i) && bus.o_ram_data == rnd) wrcnt++;
      @(posedge clk); #1;
    end
    bus.i_req_valid = 1'b0;
    check("b2b_writes", wrcnt, 32'd8);
    check("b2b_cycles", t1 - t0, 32'd7);

    // Empty store
    issue(1'b1, 10'd3, 4'h0, 32'h1357_9BDF, 1'b1);
`ifdef PQR5_DMEM_RMW_EN
    check("empty_ram_en", {31'd0, bus.o_ram_en}, 32'd0);
`else
    check("empty_ram_en", {31'd0, bus.o_ram_en}, 32'd1);
    check("empty_ram_data", bus.o_ram_data, 32'h1357_9BDF);
`endif
    tick();
    issue(1'b0, 10'd3, 4'h0, 32'h0, 1'b1); tick();

    // Reset in the RMW write cycle aborts the merge
`ifdef PQR5_DMEM_RMW_EN
    rmw_commit = 1'b0;
`else
    rmw_commit = 1'b1;
`endif
    issue(1'b1, 10'd9, 4'hF, 32'h5566_7788, 1'b1); tick();
    issue(1'b1, 10'd9, 4'b0011, 32'h0000_AAAA, rmw_commit); tick();
    aresetn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("rmw_reset");
    repeat (2) @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rmw_reset_idle", {31'd0, bus.o_req_ready}, 32'd1);
    @(posedge clk); #1;
    issue(1'b0, 10'd9, 4'h0, 32'h0, 1'b1); tick();

    // Randomized traffic
    rand_rsp = 1'b1;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 3);
      rnd = $urandom;
      issue(1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? ADDR_W'(DEPTH - 1) : ADDR_W'($urandom_range(0, 15)),
            (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom_range(0, 15)),
            rnd, 1'b1);
      tick();
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_rsp = 1'b0;
    bus.i_rsp_ready = 1'b1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
    check("drain_pending", exp_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) check("ram_final", ram[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_rmw_ctrl.md
# dmem_rmw_ctrl

Request-side controller for the single-port synchronous data RAM (one-cycle read latency, read-first, no byte enables). It accepts load/store requests from the core's memory stage over a valid/ready interface and drives the RAM port. It returns load data over a valid/ready response channel. Sub-word stores become an internal read-modify-write (RMW) sequence, because the RAM only writes full words.

## Interface
- `DATA_W`, default 32: data width; must be a multiple of 8.
- `DEPTH`, default 1024: RAM depth in words.
- `ADDR_W`, default `$clog2(DEPTH)`: derived word-address width; not overridable.
- `BE_W`, default `DATA_W/8`: derived byte-enable width.
- `clk`  in  1  clock.
- `aresetn`  in  1  reset; asynchronous assert, active-low.
- `i_req_valid`  in  1  request valid.
- `o_req_ready`  out  1  request ready.
- `i_req_wen`  in  1  1 = store, 0 = load.
- `i_req_addr`  in  ADDR_W  word address.
- `i_req_be`  in  BE_W  store byte enables; ignored for loads.
- `i_req_data`  in  DATA_W  store data.
- `o_rsp_valid`  out  1  load response valid.
- `i_rsp_ready`  in  1  load response ready.
- `o_rsp_data`  out  DATA_W  load data.
- `o_ram_en`  out  1  RAM enable.
- `o_ram_wen`  out  1  RAM write enable.
- `o_ram_addr`  out  ADDR_W  RAM address.
- `o_ram_data`  out  DATA_W  RAM write data.
- `i_ram_data`  in  DATA_W  RAM read data; valid one cycle after a RAM read.

## Operation
- The FSM has three states: IDLE, RD_RSP and RMW_WR.
- **IDLE**
  - `o_req_ready`=1.
  - A request is accepted when `i_req_valid` and `o_req_ready` are both 1.
  - On accept, the RAM port is driven combinationally from the request in the same cycle.
- **Load accept:** `o_ram_en`=1, `o_ram_wen`=0, `o_ram_addr`=`i_req_addr`; go to RD_RSP.
- **Full store** (`i_req_be` all ones): `o_ram_en`=1, `o_ram_wen`=1, `o_ram_data`=`i_req_data`; stay in IDLE. Sustained throughput is one store per cycle.
- **Partial store** (`i_req_be` neither zero nor all ones):
  - Issue a RAM read at `i_req_addr`.
  - Register the address, byte enables and data.
  - Go to RMW_WR.
- **Empty store** (`i_req_be`=0): accepted, no RAM access, stay in IDLE.
- **RD_RSP**
  - `o_req_ready`=0, `o_rsp_valid`=1, `o_rsp_data`=`i_ram_data` (the RAM holds its output because `o_ram_en`=0).
  - Stays in RD_RSP while `i_rsp_ready`=0; `o_rsp_data` stays stable.
  - On `i_rsp_ready`=1, go to IDLE.
- **RMW_WR**
  - `o_req_ready`=0, `o_ram_en`=1, `o_ram_wen`=1, `o_ram_addr`=registered address.
  - `o_ram_data`: each byte k comes from the registered store data if be[k]=1, otherwise from `i_ram_data`.
  - Go to IDLE.
- When not accessing the RAM, all RAM outputs are 0 (`o_ram_en`=0).
- Stores never produce a response.
- Ordering: requests complete strictly in acceptance order. A load after a partial store to the same address returns the merged data.

## Timing
- Reset values:
  - state = IDLE.
  - `o_rsp_valid`=0, `o_req_ready`=1 after release.
  - `o_rsp_data`=0 until the first RD_RSP.
  - `o_ram_en`=0, `o_ram_wen`=0, `o_ram_addr`=0, `o_ram_data`=0.
- Load latency: accept at cycle N, `o_rsp_valid`=1 at N+1. Minimum of 2 cycles per load.
- Full store: RAM write in the accept cycle.
- Partial store: RAM read at N, RAM write at N+1, next accept at N+2.
- While `o_req_ready`=0, the request inputs are ignored and the requester holds them.
- `o_rsp_valid` is never deasserted without a handshake, except on reset.
- Reset mid-RMW (during RMW_WR) aborts the sequence: no write, the RAM word is unchanged.
- Reset during RD_RSP drops the response.
- Address has no wrap logic: `i_req_addr` is ADDR_W bits, so the top index maps directly.

## Configuration
- `PQR5_DMEM_RMW_EN` defined:
  - Partial stores take the RMW path described above.
- Not defined:
  - `i_req_be` is ignored.
  - Every store is a single-cycle full-word write of `i_req_data`, including be=0.
  - RMW_WR state and the merge registers are not built.

## Test plan
- **Reset:** assert `aresetn`=0 mid-run → all outputs at reset values. Release → `o_req_ready`=1 on the next cycle.
- **Load backpressure:**
  - Full store of 0xDEADBEEF to addr 0x10.
  - Load addr 0x10 with `i_rsp_ready`=0 for 3 cycles → `o_rsp_valid` held, `o_rsp_data`=0xDEADBEEF stable, `o_req_ready`=0.
  - Raise `i_rsp_ready` → IDLE next cycle.
- **Partial store:**
  - Word 0x11223344 at addr 5; store data 0xAABBCCDD with be=4'b0101 → RAM written with 0x11BB33DD at cycle N+1.
  - A following load returns 0x11BB33DD.
- **Back-to-back full stores:** addrs 0..7 on consecutive cycles → 8 RAM writes in 8 cycles, `o_req_ready` constantly 1.
- **Empty store:** be=0 to addr 3 → `o_ram_en` stays 0, addr 3 unchanged. Without `PQR5_DMEM_RMW_EN`, the same stimulus writes the full word.
- **Reset mid-RMW:** assert `aresetn` in the RMW_WR cycle → addr keeps its old value, FSM in IDLE.
